// File: rtl/ks_subtractor_pipe.sv
// Three-stage elastic Kogge-Stone subtractor: Diff = A - B - borrow_in, computed as A + ~B + ~borrow_in.
// The prefix tree is split between R1 and R2; R2 drives every output.
module ks_subtractor_pipe #(
    parameter int OPERAND_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPERAND_SIZE-1:0] A,
    input  logic [OPERAND_SIZE-1:0] B,
    input  logic                    borrow_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OPERAND_SIZE-1:0] Diff,
    output logic                    borrow_out,
    output logic                    overflow,
    output logic                    zero
);
    localparam int W  = OPERAND_SIZE;
    localparam int L  = $clog2(OPERAND_SIZE);
    localparam int L1 = (L + 1) / 2;

    // Applies prefix levels lo..hi; level k combines bit i with bit i-2^(k-1).
    function automatic logic [2*W-1:0] ks_levels(input logic [W-1:0] g_in,
                                                 input logic [W-1:0] p_in,
                                                 input int lo, input int hi);
        logic [W-1:0] g, p, gn, pn;
        g = g_in;
        p = p_in;
        for (int k = 1; k <= L; k++) begin
            if (k >= lo && k <= hi) begin
                gn = g;
                pn = p;
                for (int i = 0; i < W; i++) begin
                    if (i >= (1 << (k - 1))) begin
                        gn[i] = g[i] | (g[i - (1 << (k - 1))] & p[i]);
                        pn[i] = p[i - (1 << (k - 1))] & p[i];
                    end
                end
                g = gn;
                p = pn;
            end
        end
        return {g, p};
    endfunction

    logic v0, v1, v2;
    logic load0, load1, load2;

    logic [W-1:0] p0, g0;
    logic         cin0, as0, bs0;

    logic [W-1:0] gg1, pp1;
    logic [W-1:0] grp_g1, grp_p1, pb1;
    logic         cin1, as1, bs1;

    logic [W-1:0] gg2, pp2;
    logic [W:0]   carry;
    logic [W-1:0] diff_c;
    logic         bout_c, ovf_c, zero_c;

    assign load2     = ~v2 | out_ready;
    assign load1     = ~v1 | load2;
    assign load0     = ~v0 | load1;
    assign in_ready  = load0;
    assign out_valid = v2;

    assign {gg1, pp1} = ks_levels(g0, p0, 1, L1);
    assign {gg2, pp2} = ks_levels(grp_g1, grp_p1, L1 + 1, L);

    // carry[i] is the carry into bit i; carry[0] is the inverted borrow.
    assign carry  = {gg2 | (pp2 & {W{cin1}}), cin1};
    assign diff_c = pb1 ^ carry[W-1:0];
    assign bout_c = ~carry[W];
    assign ovf_c  = (as1 != bs1) & (diff_c[W-1] != as1);
    assign zero_c = ~|diff_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            v0         <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            Diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else begin
            if (load0) v0 <= in_valid;
            if (load1) v1 <= v0;
            if (load2) begin
                v2         <= v1;
                Diff       <= diff_c;
                borrow_out <= bout_c;
                overflow   <= ovf_c;
                zero       <= zero_c;
            end
        end
    end

    // Contents of R0/R1 are don't-care while the stage is invalid, so no reset.
    always_ff @(posedge clk) begin
        if (load0) begin
            p0   <= A ^ ~B;
            g0   <= A & ~B;
            cin0 <= ~borrow_in;
            as0  <= A[W-1];
            bs0  <= B[W-1];
        end
        if (load1) begin
            grp_g1 <= gg1;
            grp_p1 <= pp1;
            pb1    <= p0;
            cin1   <= cin0;
            as1    <= as0;
            bs1    <= bs0;
        end
    end
endmodule
